// File: rtl/vector_normaliser_pkg.sv
// Shared types and width helpers for the vector normaliser and its users.
package vec_norm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    QUANT,
    INV_REQ,
    INV_WAIT,
    SCALE,
    OUT
  } state_t;

  // Sum of N squares of a W-bit signed value needs 2W bits plus growth.
  function automatic int acc_width(input int w, input int n_ch);
    return 2 * w + $clog2(n_ch);
  endfunction

  // Half an LSB of the magnitude format, expressed in accumulator LSBs.
  function automatic int round_const(input int in_fract, input int mag_fract);
    return 1 << (2 * in_fract - mag_fract - 1);
  endfunction

endpackage

// File: rtl/vector_normaliser_fast_inv_sqrt.sv
// Bit-serial reciprocal square root: returns the largest unsigned Q(INT.FRACT)
// r with r*r*m <= 1.0, resolving one result bit per cycle.
module fastInvSqrt #(
  parameter int INT_WIDTH   = 8,
  parameter int FRACT_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             valid_in,
  output logic                             ready_in,
  input  logic [INT_WIDTH+FRACT_WIDTH-1:0] data_in,
  output logic                             valid_out,
  input  logic                             ready_out,
  output logic [INT_WIDTH+FRACT_WIDTH-1:0] data_out
);

  localparam int MW = INT_WIDTH + FRACT_WIDTH;
  localparam int BW = $clog2(MW);
  localparam logic [3*MW-1:0] ONE = (3 * MW)'(1) << (3 * FRACT_WIDTH);

  logic [MW-1:0]   m_reg;
  logic [MW-1:0]   r_reg;
  logic [MW-1:0]   trial;
  logic [BW-1:0]   bit_idx;
  logic            running;
  logic [2*MW-1:0] trial_sq;
  logic [3*MW-1:0] trial_prod;

  assign trial      = r_reg | (MW'(1) << bit_idx);
  assign trial_sq   = {{MW{1'b0}}, trial} * {{MW{1'b0}}, trial};
  assign trial_prod = {{MW{1'b0}}, trial_sq} * {{(2 * MW){1'b0}}, m_reg};
  assign ready_in   = !running && !valid_out;
  assign data_out   = r_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg     <= '0;
      r_reg     <= '0;
      bit_idx   <= '0;
      running   <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      if (valid_out && ready_out) valid_out <= 1'b0;
      if (running) begin
        if (trial_prod <= ONE) r_reg <= trial;
        if (bit_idx == '0) begin
          running   <= 1'b0;
          valid_out <= 1'b1;
        end else begin
          bit_idx <= bit_idx - BW'(1);
        end
      end else if (valid_in && ready_in) begin
        m_reg   <= data_in;
        r_reg   <= '0;
        bit_idx <= BW'(MW - 1);
        running <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vector_normaliser.sv
// N-channel fixed-point vector normaliser: v_out = v_in * invsqrt(|v_in|^2),
// one shared multiplier for both the squaring and the scaling pass.
//
// state    | meaning
// IDLE     | waiting for an input vector, in_ready high
// ACC      | accumulate ch[idx]^2, one channel per cycle
// QUANT    | round/clamp the sum to the magnitude format, detect zero
// INV_REQ  | offer the magnitude to the invsqrt unit
// INV_WAIT | wait for and latch the reciprocal root
// SCALE    | out[idx] = sat(round(ch[idx] * r)), one channel per cycle
// OUT      | present the result until out_ready
module vector_normaliser
  import vec_norm_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int IN_INT_WIDTH    = 8,
  parameter int IN_FRACT_WIDTH  = 8,
  parameter int MAG_INT_WIDTH   = 8,
  parameter int MAG_FRACT_WIDTH = 8
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [N_CH*(IN_INT_WIDTH+IN_FRACT_WIDTH)-1:0]   in_data,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [N_CH*(IN_INT_WIDTH+IN_FRACT_WIDTH)-1:0]   out_data,
  output logic                                            out_zero,
  output logic                                            out_sat,
  output logic                                            busy
);

  localparam int W   = IN_INT_WIDTH + IN_FRACT_WIDTH;
  localparam int MW  = MAG_INT_WIDTH + MAG_FRACT_WIDTH;
  localparam int BW  = (W > MW) ? W : MW;
  localparam int PW  = W + BW;
  localparam int AW  = acc_width(W, N_CH);
  localparam int IW  = $clog2(N_CH);
  localparam int QSH = 2 * IN_FRACT_WIDTH - MAG_FRACT_WIDTH;

  localparam logic [AW:0]        QRND    = (AW + 1)'(round_const(IN_FRACT_WIDTH, MAG_FRACT_WIDTH));
  localparam logic signed [PW:0] SRND    = (PW + 1)'(2 ** (MAG_FRACT_WIDTH - 1));
  localparam logic signed [PW:0] OUT_MAX = (PW + 1)'(2 ** (W - 1) - 1);
  localparam logic signed [PW:0] OUT_MIN = (PW + 1)'(-(2 ** (W - 1)));

  state_t                state;
  logic [IW-1:0]         idx;
  logic [W-1:0]          ch_reg [N_CH];
  logic [AW-1:0]         acc;
  logic [MW-1:0]         mag;
  logic signed [MW-1:0]  r_reg;

  logic                  idx_last;
  logic signed [W-1:0]   mul_a;
  logic signed [BW-1:0]  mul_b;
  logic signed [PW-1:0]  mul_p;
  logic [AW:0]           acc_rnd;
  logic [AW:0]           mag_full;
  logic                  mag_ovf;
  logic [MW-1:0]         mag_q;
  logic signed [PW:0]    p_rnd;
  logic signed [PW:0]    p_sh;
  logic [W-1:0]          p_out;
  logic                  p_clip;

  logic                  inv_valid_in;
  logic                  inv_ready_in;
  logic                  inv_valid_out;
  logic                  inv_ready_out;
  logic [MW-1:0]         inv_data_out;

  assign in_ready      = (state == IDLE);
  assign busy          = (state != IDLE);
  assign idx_last      = (idx == IW'(N_CH - 1));
  assign inv_valid_in  = (state == INV_REQ);
  assign inv_ready_out = (state == INV_WAIT);

  // The single multiplier squares in ACC and scales by r in SCALE.
  always_comb begin
    mul_a = signed'(ch_reg[idx]);
    if (state == SCALE) mul_b = BW'(r_reg);
    else                mul_b = BW'(mul_a);
  end

  assign mul_p = PW'(mul_a) * PW'(mul_b);

  // Magnitude^2: round half-up into the invsqrt format, clamp on overflow.
  assign acc_rnd  = {1'b0, acc} + QRND;
  assign mag_full = acc_rnd >> QSH;
  assign mag_ovf  = |mag_full[AW:MW];
  assign mag_q    = mag_ovf ? {MW{1'b1}} : mag_full[MW-1:0];

  assign p_rnd = (PW + 1)'(mul_p) + SRND;
  assign p_sh  = p_rnd >>> MAG_FRACT_WIDTH;

  always_comb begin
    p_clip = 1'b0;
    p_out  = p_sh[W-1:0];
    if (p_sh > OUT_MAX) begin
      p_out  = {1'b0, {(W - 1){1'b1}}};
      p_clip = 1'b1;
    end else if (p_sh < OUT_MIN) begin
      p_out  = {1'b1, {(W - 1){1'b0}}};
      p_clip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      mag       <= '0;
      r_reg     <= '0;
      out_data  <= '0;
      out_zero  <= 1'b0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < N_CH; i++) ch_reg[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N_CH; i++) ch_reg[i] <= in_data[i*W +: W];
            acc      <= '0;
            idx      <= '0;
            out_zero <= 1'b0;
            out_sat  <= 1'b0;
            state    <= ACC;
          end
        end
        ACC: begin
          acc <= acc + AW'($unsigned(mul_p));
          if (idx_last) begin
            idx   <= '0;
            state <= QUANT;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        QUANT: begin
          mag <= mag_q;
          if (mag_ovf) out_sat <= 1'b1;
          // A zero magnitude has no reciprocal root; skip straight to the result.
          if (mag_q == '0) begin
            out_data <= '0;
            out_zero <= 1'b1;
            state    <= OUT;
          end else begin
            state <= INV_REQ;
          end
        end
        INV_REQ: begin
          if (inv_ready_in) state <= INV_WAIT;
        end
        INV_WAIT: begin
          if (inv_valid_out) begin
            r_reg <= signed'(inv_data_out);
            state <= SCALE;
          end
        end
        SCALE: begin
          out_data[idx*W +: W] <= p_out;
          if (p_clip) out_sat <= 1'b1;
          if (idx_last) begin
            idx   <= '0;
            state <= OUT;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fastInvSqrt #(
    .INT_WIDTH   (MAG_INT_WIDTH),
    .FRACT_WIDTH (MAG_FRACT_WIDTH)
  ) u_inv (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (inv_valid_in),
    .ready_in  (inv_ready_in),
    .data_in   (mag),
    .valid_out (inv_valid_out),
    .ready_out (inv_ready_out),
    .data_out  (inv_data_out)
  );

endmodule

// File: tb/tb_vector_normaliser.sv
// Self-checking bench: directed spec cases plus randomized vectors against a
// plain-arithmetic model of the normalisation rules.
`timescale 1ns/1ps
module tb_vector_normaliser;
  import vec_norm_pkg::*;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int IF_W  = 8;
  localparam int MF    = 8;
  localparam int MW    = 16;
  localparam int L_INV = MW + 1;
  localparam int LAT   = 2 * N + 3 + L_INV;
  localparam int LAT_Z = N + 2;

  typedef struct {
    logic [N*W-1:0] data;
    bit             zero;
    bit             sat;
    int             lat;
    int             acc_cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [N*W-1:0] out_data;
  logic           out_zero, out_sat, busy;

  logic           in_valid3 = 1'b0;
  logic           in_ready3;
  logic [3*W-1:0] in_data3 = '0;
  logic           out_valid3;
  logic           out_ready3 = 1'b1;
  logic [3*W-1:0] out_data3;
  logic           out_zero3, out_sat3, busy3;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t ce;
  bit   rand_ready = 1'b0;
  bit   ready_force = 1'b1;
  bit   prev_valid = 1'b0;
  bit   inv_seen = 1'b0;
  logic [N*W-1:0] hold_data;
  bit   hold_zero, hold_sat;
  logic [N*W-1:0] last_data;
  bit   last_zero, last_sat;
  int   last_lat;

  vector_normaliser #(.N_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_sat(out_sat), .busy(busy)
  );

  vector_normaliser #(.N_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_zero(out_zero3), .out_sat(out_sat3), .busy(busy3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    else            out_ready = ready_force;
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic longint isqrt(input longint x);
    longint r;
    r = longint'($sqrt(real'(x)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // r is the largest Q8.8 value with r^2 * |v|^2 <= 1, i.e. floor of 1/|v|.
  function automatic exp_t model(input logic [N*W-1:0] v);
    exp_t e;
    longint acc, mag, r, q, c;
    logic signed [W-1:0] cs;
    acc = 0;
    e.data = '0; e.zero = 0; e.sat = 0; e.acc_cyc = 0;
    for (int i = 0; i < N; i++) begin
      cs = v[i*W +: W]; c = cs; acc += c * c;
    end
    mag = (acc + (longint'(1) << (2 * IF_W - MF - 1))) >> (2 * IF_W - MF);
    if (mag > (longint'(1) << MW) - 1) begin
      mag = (longint'(1) << MW) - 1;
      e.sat = 1;
    end
    if (mag == 0) begin
      e.zero = 1;
      e.lat  = LAT_Z;
    end else begin
      r = isqrt((longint'(1) << (3 * MF)) / mag);
      for (int i = 0; i < N; i++) begin
        cs = v[i*W +: W]; c = cs;
        q = (c * r + (longint'(1) << (MF - 1))) >>> MF;
        if (q > 32767)  begin q = 32767;  e.sat = 1; end
        if (q < -32768) begin q = -32768; e.sat = 1; end
        e.data[i*W +: W] = q[W-1:0];
      end
      e.lat = LAT;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (dut.inv_valid_in) inv_seen = 1'b1;
      if (out_valid) begin
        check("in_ready_while_out", in_ready, 0);
        if (!prev_valid) begin
          check("output_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            ce = exp_q[0];
            check("out_data", out_data, ce.data);
            check("out_zero", out_zero, ce.zero);
            check("out_sat", out_sat, ce.sat);
            check("latency", cyc - ce.acc_cyc, ce.lat);
            if (ce.zero) check("inv_skipped", inv_seen, 0);
            last_data = out_data; last_zero = out_zero; last_sat = out_sat;
            last_lat = cyc - ce.acc_cyc;
          end
          hold_data = out_data; hold_zero = out_zero; hold_sat = out_sat;
        end else begin
          check("hold_data", out_data, hold_data);
          check("hold_flags", {out_zero, out_sat}, {hold_zero, hold_sat});
        end
        if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      prev_valid = out_valid;
    end
  end

  task automatic send(input logic [N*W-1:0] v);
    exp_t e;
    int   guard;
    e = model(v);
    guard = 0;
    in_data = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("accept_timeout", guard < 300, 1);
    e.acc_cyc = cyc + 1;
    inv_seen = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    int kind, lim, x;
    kind = $urandom_range(0, 9);
    lim = (kind == 0) ? 0 : (kind == 1) ? 15 : (kind == 2) ? 32767 : 512;
    for (int i = 0; i < N; i++) begin
      x = int'($urandom_range(0, 2 * lim)) - lim;
      v[i*W +: W] = x[W-1:0];
    end
    return v;
  endfunction

  initial begin
    exp_t pm;
    logic [N*W-1:0] cap;
    logic [W-1:0]   d3;
    int g, acc3, seen;

    // model pins against hand-computed values
    pm = model(64'h0000_0000_0000_0100);
    check("model_unit", pm.data, 64'h0000_0000_0000_0100);
    pm = model(64'h0000_0000_0400_0300);
    check("model_3_4", pm.data, 64'h0000_0000_00CC_0099);
    pm = model(64'h7FFF_7FFF_7FFF_7FFF);
    check("model_sat", {pm.data[15:0], 15'd0, pm.sat}, {16'h0800, 15'd0, 1'b1});

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_flags", {out_zero, out_sat}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(64'h0000_0000_0000_0100);
    drain();
    check("unit_data", last_data, 64'h0000_0000_0000_0100);
    check("unit_flags", {last_zero, last_sat}, 0);

    send(64'h0080_0080_0080_0080);
    drain();
    check("equal_data", last_data, 64'h0080_0080_0080_0080);
    check("equal_latency", last_lat, 28);

    send(64'h0);
    drain();
    check("zero_data", last_data, 0);
    check("zero_flag", last_zero, 1);
    check("zero_latency", last_lat, 6);
    check("zero_no_invsqrt", inv_seen, 0);

    send(64'h7FFF_7FFF_7FFF_7FFF);
    drain();
    check("sat_pos_data", last_data, 64'h0800_0800_0800_0800);
    check("sat_pos_flag", last_sat, 1);

    send(64'h8000_8000_8000_8000);
    drain();
    check("sat_neg_data", last_data, 64'hF800_F800_F800_F800);
    check("sat_neg_flag", last_sat, 1);

    send(64'h0000_0000_0400_0300);
    drain();
    check("n4_3_4_data", last_data, 64'h0000_0000_00CC_0099);

    // N_CH=3 build: (3,4,0) -> (0.6,0.8,0) within 2 LSB
    in_data3 = {16'h0000, 16'h0400, 16'h0300};
    in_valid3 = 1'b1;
    @(negedge clk);
    check("n3_in_ready", in_ready3, 1);
    acc3 = cyc + 1;
    @(posedge clk);
    #1 in_valid3 = 1'b0;
    g = 0;
    @(negedge clk);
    while (!out_valid3 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("n3_timeout", out_valid3, 1);
    check("n3_latency", cyc - acc3, 2 * 3 + 3 + L_INV);
    d3 = out_data3[15:0];
    check("n3_ch0_tol", (d3 >= 16'h0098 && d3 <= 16'h009C), 1);
    d3 = out_data3[31:16];
    check("n3_ch1_tol", (d3 >= 16'h00CB && d3 <= 16'h00CF), 1);
    d3 = out_data3[47:32];
    check("n3_ch2_tol", (d3 <= 16'h0002 || d3 >= 16'hFFFE), 1);
    check("n3_flags", {out_zero3, out_sat3}, 0);
    @(posedge clk);
    #1;

    // back-pressure: result must hold while out_ready is low
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    send(64'hFF00_0200_0180_FE80);
    g = 0;
    @(negedge clk);
    while (!out_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("bp_timeout", out_valid, 1);
    cap = out_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_stable", out_data, cap);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
    end
    ready_force = 1'b1;
    drain();

    // reset in the middle of SCALE
    send(64'h0100_0100_0100_0100);
    g = 0;
    while (dut.state != SCALE && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("reach_scale", dut.state == SCALE, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_partial_result", seen, 0);
    @(posedge clk);
    #1;

    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) send(rand_vec());
    drain();
    rand_ready = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
